// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of a FIFO among
// N_REQ requesters. The winner's index and data word are latched, written to
// the FIFO for one cycle, and the registered write acknowledge is checked.
// An accepted write returns a one-cycle done pulse to the requester. A refused
// write retries the same requester with the same data once the FIFO is no
// longer full.
//
// Optional build macro: FIFO_ARB_STATS_EN
//   defined   : saturating accepted-write and refused-write counters
//   undefined : no counter flops; acc_cnt and retry_cnt are tied to 0
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   req           in   per-requester request, held until its done bit pulses
//   req_data      in   packed data words, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   done          out  one-hot, one-cycle pulse: requester i's write accepted
//   busy          out  high whenever the arbiter is not in ARB
//   fifo_wr_en    out  FIFO write enable
//   fifo_data_in  out  FIFO write data
//   fifo_full     in   FIFO full flag
//   fifo_wr_ack   in   FIFO write acknowledge, valid the cycle after fifo_wr_en
//   fifo_overflow in   FIFO overflow flag, valid the cycle after fifo_wr_en
//   acc_cnt       out  accepted-write count (0 unless FIFO_ARB_STATS_EN)
//   retry_cnt     out  refused-with-overflow count (0 unless FIFO_ARB_STATS_EN)
//
// State | meaning
// ------+----------------------------------------------------------------
// ARB   | idle; pick the next requester from ptr when the FIFO is not full
// WR    | fifo_wr_en asserted with the latched data for this one cycle
// ACK   | sample fifo_wr_ack; done pulse on accept, HOLD on refusal
// HOLD  | refused write parked until fifo_full drops; same idx and data
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            done,
    output logic                        busy,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [15:0]                 acc_cnt,
    output logic [15:0]                 retry_cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] data_q;

    logic [N_REQ-1:0]      cand;
    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] slice [N_REQ];

    // A requester whose done pulse is out this cycle still has its stale req
    // high; masking with done keeps it from being granted a second time.
    assign cand = req & ~done;

    always_comb begin
        logic [IW:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slice[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        // Cyclic scan starting at ptr; the explicit subtract keeps the wrap
        // correct for non-power-of-two N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N_REQ)) begin
                pos = pos - (IW+1)'(N_REQ);
            end
            if (!win_found && cand[pos[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            ptr        <= '0;
            idx        <= '0;
            data_q     <= '0;
            fifo_wr_en <= 1'b0;
            done       <= '0;
        end else begin
            done       <= '0;
            fifo_wr_en <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (win_found && !fifo_full) begin
                        idx        <= win_idx;
                        data_q     <= slice[win_idx];
                        fifo_wr_en <= 1'b1;
                        state      <= ST_WR;
                    end
                end
                ST_WR: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (fifo_wr_ack) begin
                        done  <= {{(N_REQ-1){1'b0}}, 1'b1} << idx;
                        ptr   <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
                        state <= ST_ARB;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!fifo_full) begin
                        fifo_wr_en <= 1'b1;
                        state      <= ST_WR;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

    // data_q is only loaded on a grant, so it doubles as the registered
    // write-data output and stays stable across retries.
    assign fifo_data_in = data_q;
    assign busy         = (state != ST_ARB);

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] acc_q;
    logic [15:0] retry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            retry_q <= '0;
        end else if (state == ST_ACK) begin
            if (fifo_wr_ack) begin
                if (acc_q != 16'hFFFF) begin
                    acc_q <= acc_q + 16'd1;
                end
            end else if (fifo_overflow) begin
                if (retry_q != 16'hFFFF) begin
                    retry_q <= retry_q + 16'd1;
                end
            end
        end
    end

    assign acc_cnt   = acc_q;
    assign retry_cnt = retry_q;
`else
    // Overflow only qualifies the retry counter, which is not built here.
    logic unused_overflow;
    assign unused_overflow = fifo_overflow;
    assign acc_cnt         = '0;
    assign retry_cnt       = '0;
`endif

endmodule
